key_conditioner: RTL and testbench

//  Debounces and conditions the raw push-button inputs of the digital clock (minute/hour adjust, alarm set keys).

---
 rtl/key_conditioner.sv | 257 +++++++++++++++++++++++++
 tb/tb_key_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner
//   Debounces and conditions the raw push-button inputs of the digital clock
//   (minute/hour adjust, alarm set keys). Each channel gives a clean pressed
//   level, a single-cycle press pulse, a repeat pulse stream for held keys and
//   a flag marking auto-repeat. Everything runs on CLK_50 and uses one shared
//   debounce tick; there are no derived clocks.
//
// Ports
//   CLK_50     in   1       system clock, all logic on the rising edge
//   CR         in   1       synchronous active-high reset
//   key_raw    in   N_KEYS  asynchronous raw key pins
//   key_level  out  N_KEYS  debounced pressed level (1 = pressed)
//   key_press  out  N_KEYS  1-cycle pulse on each accepted press
//   key_rpt    out  N_KEYS  1-cycle pulse on accepted press and on every auto-repeat
//   key_long   out  N_KEYS  1 while the key is in auto-repeat
//
// Parameters
//   N_KEYS       number of independent key channels
//   TICK_CYCLES  CLK_50 cycles per debounce tick
//   DB_TICKS     consecutive stable ticks to accept a press or a release
//   DELAY_TICKS  ticks held after an accepted press before auto-repeat starts
//   RATE_TICKS   ticks between auto-repeat pulses
//   ACTIVE_LOW   1: pin reads 0 when pressed; 0: pin reads 1 when pressed

module key_conditioner #(
  parameter int N_KEYS      = 4,
  parameter int TICK_CYCLES = 50000,
  parameter int DB_TICKS    = 20,
  parameter int DELAY_TICKS = 500,
  parameter int RATE_TICKS  = 100,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              CLK_50,
  input  logic              CR,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_rpt,
  output logic [N_KEYS-1:0] key_long
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (N_KEYS < 1 || TICK_CYCLES < 1 || DB_TICKS < 1 || DELAY_TICKS < 1 ||
      RATE_TICKS < 1) begin : gen_param_err
    $error("key_conditioner: all count parameters must be >= 1");
  end

  if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : gen_polarity_err
    $error("key_conditioner: ACTIVE_LOW must be 0 or 1");
  end

  // ---------------------------------------------------------------------------
  // Derived widths and terminal counts
  // ---------------------------------------------------------------------------
  localparam int MaxDbDelay = (DB_TICKS > DELAY_TICKS) ? DB_TICKS : DELAY_TICKS;
  localparam int MaxTicks   = (MaxDbDelay > RATE_TICKS) ? MaxDbDelay : RATE_TICKS;
  // Terminal value is MaxTicks-1, so $clog2(MaxTicks) bits suffice; keep >= 1 bit.
  localparam int CntW       = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam int PreW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [PreW-1:0] PreLast   = PreW'(TICK_CYCLES - 1);
  localparam logic [CntW-1:0] DbLast    = CntW'(DB_TICKS - 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(DELAY_TICKS - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(RATE_TICKS - 1);

  // Pin level of a released key; the synchronizer resets to this value so that
  // a key still held through reset is seen as a fresh press afterwards.
  localparam logic RelLevel = (ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    StIdle,
    StPwait,
    StHeld,
    StRpt,
    StRwait
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-stage synchronizer and polarity normalisation
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] act;

  always_ff @(posedge CLK_50) begin
    if (CR) begin
      sync1_q <= {N_KEYS{RelLevel}};
      sync2_q <= {N_KEYS{RelLevel}};
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    act = sync2_q;
    if (ACTIVE_LOW != 0) begin
      act = ~sync2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared tick prescaler: tick is high for the single cycle at TICK_CYCLES-1
  // ---------------------------------------------------------------------------
  logic [PreW-1:0] presc_q;
  logic [PreW-1:0] presc_d;
  logic            tick;

  always_comb begin
    tick    = (presc_q == PreLast);
    presc_d = tick ? '0 : presc_q + PreW'(1);
  end

  always_ff @(posedge CLK_50) begin
    if (CR) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce / auto-repeat FSM
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_KEYS; g++) begin : gen_ch
    state_e          state_q;
    state_e          state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            level_q;
    logic            level_d;
    logic            long_q;
    logic            long_d;
    logic            press_q;
    logic            press_d;
    logic            rpt_q;
    logic            rpt_d;

    always_ff @(posedge CLK_50) begin
      if (CR) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        level_q <= 1'b0;
        long_q  <= 1'b0;
        press_q <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        long_q  <= long_d;
        press_q <= press_d;
        rpt_q   <= rpt_d;
      end
    end

    // In every state the act check comes first, so an act change wins over a
    // tick arriving in the same cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      long_d  = long_q;
      press_d = 1'b0;
      rpt_d   = 1'b0;

      unique case (state_q)
        StIdle: begin
          if (act[g]) begin
            state_d = StPwait;
            cnt_d   = '0;
          end
        end

        StPwait: begin
          if (!act[g]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == DbLast) begin
              state_d = StHeld;
              cnt_d   = '0;
              press_d = 1'b1;
              rpt_d   = 1'b1;
              level_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end

        StHeld: begin
          if (!act[g]) begin
            state_d = StRwait;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == DelayLast) begin
              state_d = StRpt;
              cnt_d   = '0;
              rpt_d   = 1'b1;
              long_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end

        StRpt: begin
          if (!act[g]) begin
            state_d = StRwait;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == RateLast) begin
              cnt_d = '0;
              rpt_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end

        StRwait: begin
          // A bounce during release resumes where the key was, without a new
          // press pulse; key_level stays up until the release is accepted.
          if (act[g]) begin
            state_d = long_q ? StRpt : StHeld;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == DbLast) begin
              state_d = StIdle;
              cnt_d   = '0;
              level_d = 1'b0;
              long_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          level_d = 1'b0;
          long_d  = 1'b0;
        end
      endcase
    end

    assign key_level[g] = level_q;
    assign key_press[g] = press_q;
    assign key_rpt[g]   = rpt_q;
    assign key_long[g]  = long_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with a short tick (4 cycles),
// DB_TICKS=3, DELAY_TICKS=5, RATE_TICKS=2 and active-low keys.
// After a reset the prescaler is 0, so ticks are seen at edges 4, 8, 12, ...
// counted from the last reset edge; a key pressed before edge 1 is seen as
// act=1 from edge 3 and its press pulse is sampled right after edge 12.

module tb_key_conditioner;

  localparam int NK = 4;

  logic          CLK_50;
  logic          CR;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_rpt;
  logic [NK-1:0] key_long;

  int n_checks;
  int n_fail;

  key_conditioner #(
    .N_KEYS     (NK),
    .TICK_CYCLES(4),
    .DB_TICKS   (3),
    .DELAY_TICKS(5),
    .RATE_TICKS (2),
    .ACTIVE_LOW (1)
  ) dut (
    .CLK_50   (CLK_50),
    .CR       (CR),
    .key_raw  (key_raw),
    .key_level(key_level),
    .key_press(key_press),
    .key_rpt  (key_rpt),
    .key_long (key_long)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  typedef struct {
    logic [NK-1:0] mask;       // keys pressed together
    int            hold;       // cycles held from edge 1
    int            exp_press;  // press pulses per pressed key
    int            exp_rpt;    // repeat pulses per pressed key
    logic          exp_level;  // level right after the hold is fully seen
    logic          exp_long;   // long flag right after the hold is fully seen
  } row_t;

  row_t rows[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic do_reset();
    key_raw = '1;
    CR      = 1'b1;
    step();
    step();
    CR = 1'b0;
  endtask

  task automatic run_row(input int idx, input row_t r);
    int press_cnt[NK];
    int rpt_cnt[NK];
    int first[NK];
    logic [NK-1:0] lvl_a, long_a, lvl_b;
    for (int c = 0; c < NK; c++) begin
      press_cnt[c] = 0;
      rpt_cnt[c]   = 0;
      first[c]     = 0;
    end
    lvl_a  = '0;
    long_a = '0;
    lvl_b  = '0;
    do_reset();
    for (int cyc = 1; cyc <= r.hold + 24; cyc++) begin
      key_raw = (cyc <= r.hold) ? ~r.mask : '1;
      step();
      for (int c = 0; c < NK; c++) begin
        press_cnt[c] += int'(key_press[c]);
        rpt_cnt[c]   += int'(key_rpt[c]);
        if (key_press[c] && first[c] == 0) first[c] = cyc;
      end
      if (cyc == r.hold + 2) begin
        lvl_a  = key_level;
        long_a = key_long;
      end
      if (cyc == r.hold + 6) lvl_b = key_level;
    end
    for (int c = 0; c < NK; c++) begin
      check($sformatf("row%0d press_cnt[%0d]", idx, c), press_cnt[c],
            r.mask[c] ? r.exp_press : 0);
      check($sformatf("row%0d rpt_cnt[%0d]", idx, c), rpt_cnt[c],
            r.mask[c] ? r.exp_rpt : 0);
      check($sformatf("row%0d first_press[%0d]", idx, c), first[c],
            (r.mask[c] && r.exp_press > 0) ? 12 : 0);
    end
    check($sformatf("row%0d level_held", idx), 32'(lvl_a), r.exp_level ? 32'(r.mask) : 0);
    check($sformatf("row%0d long_held", idx), 32'(long_a), r.exp_long ? 32'(r.mask) : 0);
    check($sformatf("row%0d level_rwait", idx), 32'(lvl_b), r.exp_level ? 32'(r.mask) : 0);
    check($sformatf("row%0d level_end", idx), 32'(key_level), 0);
    check($sformatf("row%0d long_end", idx), 32'(key_long), 0);
  endtask

  initial begin
    int press_cnt;
    int rpt_cnt;
    int lvl_drop;
    int long_drop;
    int lvl_seen;
    int first;
    logic [3:0] pat;

    n_checks = 0;
    n_fail   = 0;
    CR       = 1'b1;
    key_raw  = '1;

    //          mask     hold press rpt level long
    rows[0] = '{4'b0001,  9,   0,   0,  1'b0, 1'b0};  // act drops on the 3rd tick
    rows[1] = '{4'b0001, 10,   1,   1,  1'b1, 1'b0};  // shortest accepted press
    rows[2] = '{4'b0100, 29,   1,   1,  1'b1, 1'b0};  // release beats the repeat tick
    rows[3] = '{4'b0100, 30,   1,   2,  1'b1, 1'b1};  // just reaches auto-repeat
    rows[4] = '{4'b0100, 60,   1,   5,  1'b1, 1'b1};  // long hold: 12,32,40,48,56
    rows[5] = '{4'b1001, 20,   1,   1,  1'b1, 1'b0};  // two keys on the same cycle
    rows[6] = '{4'b0010, 45,   1,   3,  1'b1, 1'b1};  // 12,32,40

    // Reset state
    step();
    step();
    check("reset_outputs", {key_level, key_press, key_rpt, key_long}, 0);
    CR = 1'b0;

    for (int i = 0; i < 7; i++) run_row(i, rows[i]);

    // Bounce on key 1: 5 cycles pressed, 5 released, for 40 cycles.
    do_reset();
    press_cnt = 0;
    lvl_seen  = 0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      pat = '1;
      if (cyc <= 40 && ((cyc - 1) / 5) % 2 == 0) pat[1] = 1'b0;
      key_raw = pat;
      step();
      press_cnt += int'(key_press[1]);
      if (key_level[1]) lvl_seen++;
    end
    check("bounce_press", press_cnt, 0);
    check("bounce_level", lvl_seen, 0);

    // Release glitch on key 3 while in auto-repeat: released for cycles 37..40.
    do_reset();
    press_cnt = 0;
    rpt_cnt   = 0;
    lvl_drop  = 0;
    long_drop = 0;
    for (int cyc = 1; cyc <= 84; cyc++) begin
      key_raw = ((cyc <= 36) || (cyc >= 41 && cyc <= 60)) ? 4'b0111 : 4'b1111;
      step();
      press_cnt += int'(key_press[3]);
      rpt_cnt   += int'(key_rpt[3]);
      if (cyc >= 12 && cyc <= 62 && !key_level[3]) lvl_drop++;
      if (cyc >= 32 && cyc <= 62 && !key_long[3]) long_drop++;
    end
    check("glitch_press", press_cnt, 1);
    check("glitch_rpt", rpt_cnt, 4);
    check("glitch_level_drop", lvl_drop, 0);
    check("glitch_long_drop", long_drop, 0);
    check("glitch_level_end", 32'(key_level), 0);

    // Reset while key 0 is held in auto-repeat.
    do_reset();
    key_raw = 4'b1110;
    for (int cyc = 1; cyc <= 40; cyc++) step();
    check("rst_long_before", 32'(key_long), 32'h1);
    check("rst_level_before", 32'(key_level), 32'h1);
    CR = 1'b1;
    step();
    check("rst_outputs", {key_level, key_press, key_rpt, key_long}, 0);
    CR        = 1'b0;
    press_cnt = 0;
    first     = 0;
    lvl_seen  = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      step();
      press_cnt += int'(key_press[0]);
      if (key_press[0] && first == 0) first = cyc;
      if (cyc <= 11 && key_level[0]) lvl_seen++;
    end
    check("rst_repress_cnt", press_cnt, 1);
    check("rst_repress_cycle", first, 12);
    check("rst_level_early", lvl_seen, 0);
    key_raw = '1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
